fifo_stream_out: RTL and testbench

- Pop-side adapter sitting directly downstream of the team's synchronous circular-buffer FIFO.
- Converts the FIFO's pop/empty interface into a valid/ready stream for the consuming stage (decode/issue). On that interface, data appears one cycle after pop.
- A 2-entry skid buffer sustains one transfer per cycle under backpressure.
- Honours the shared pipeline flush and counts delivered entries.

---
 rtl/fifo_stream_out.sv | 78 +++++++
 tb/tb_fifo_stream_out.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_out.sv
// Pop-side adapter: turns the upstream FIFO pop/empty interface (data one cycle
// after pop) into a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_out #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 fifo_pop,
    input  logic [WIDTH-1:0]     fifo_data,
    input  logic                 fifo_empty,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] delivered
);

    logic [WIDTH-1:0]     buf_q [2];
    logic                 head_q, head_d;
    logic                 tail_q, tail_d;
    logic                 inflight_q, inflight_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] delivered_q, delivered_d;
    logic                 deq;
    logic [2:0]           pending;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = buf_q[head_q];
    assign occupancy = cnt_q;
    assign delivered = delivered_q;

    // Pop only when the capture slot next cycle is guaranteed free.
    always_comb begin
        deq         = out_valid && out_ready;
        pending     = 3'(cnt_q) + 3'(inflight_q) - 3'(deq);
        fifo_pop    = reset_n && !flush && !fifo_empty && (pending < 3'd2);
        head_d      = head_q;
        tail_d      = tail_q;
        inflight_d  = inflight_q;
        cnt_d       = cnt_q;
        delivered_d = delivered_q + CNT_WIDTH'(deq);
        if (flush) begin
            head_d     = 1'b0;
            tail_d     = 1'b0;
            inflight_d = 1'b0;
            cnt_d      = 2'd0;
        end else begin
            inflight_d = fifo_pop;
            cnt_d      = 2'(pending);
            if (inflight_q) tail_d = ~tail_q;
            if (deq)        head_d = ~head_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            inflight_q  <= 1'b0;
            cnt_q       <= 2'd0;
            delivered_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            inflight_q  <= inflight_d;
            cnt_q       <= cnt_d;
            delivered_q <= delivered_d;
        end
    end

    // Data storage needs no reset; validity is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (inflight_q && !flush) buf_q[tail_q] <= fifo_data;
    end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: queue-based upstream FIFO and reference model,
// directed scenarios followed by randomized backpressure/flush traffic.
module tb_fifo_stream_out;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fifo_pop, fifo_pop4;
    logic [15:0] fifo_data;
    logic        fifo_empty;
    logic        flush;
    logic        out_valid, out_valid4;
    logic [15:0] out_data, out_data4;
    logic        out_ready;
    logic [1:0]  occupancy, occupancy4;
    logic [15:0] delivered;
    logic [3:0]  delivered4;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] fifo_q [$];
    logic [15:0] cap_q [$];
    logic [15:0] out_log [$];
    bit          infl;
    logic [15:0] infl_val;
    int unsigned dlv;
    int          pop_count;

    always #5 clk = ~clk;

    fifo_stream_out #(.WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .fifo_pop(fifo_pop), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .occupancy(occupancy),
        .delivered(delivered)
    );

    fifo_stream_out #(.WIDTH(16), .CNT_WIDTH(4)) dut_c4 (
        .clk(clk), .reset_n(reset_n), .fifo_pop(fifo_pop4), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .flush(flush), .out_valid(out_valid4),
        .out_data(out_data4), .out_ready(out_ready), .occupancy(occupancy4),
        .delivered(delivered4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int n, input logic [15:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) fifo_q.push_back(16'($urandom));
            else     fifo_q.push_back(base + 16'(i));
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic tick();
        bit exp_valid, deq_m, exp_pop, fl;
        int pend;
        #2;
        exp_valid = (cap_q.size() != 0);
        deq_m     = exp_valid && out_ready;
        pend      = cap_q.size() + int'(infl) - int'(deq_m);
        exp_pop   = reset_n && !flush && (fifo_q.size() != 0) && (pend < 2);
        fl        = flush;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("out_valid_c4", 32'(out_valid4), 32'(exp_valid));
        if (exp_valid) begin
            check("out_data", 32'(out_data), 32'(cap_q[0]));
            check("out_data_c4", 32'(out_data4), 32'(cap_q[0]));
        end
        check("occupancy", 32'(occupancy), 32'(cap_q.size()));
        check("occupancy_c4", 32'(occupancy4), 32'(cap_q.size()));
        check("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
        check("fifo_pop_c4", 32'(fifo_pop4), 32'(exp_pop));
        check("pop_on_empty", 32'(fifo_pop && fifo_empty), 32'(0));
        check("delivered", 32'(delivered), 32'(16'(dlv)));
        check("delivered_c4", 32'(delivered4), 32'(4'(dlv)));
        if (fifo_pop) pop_count++;
        if (deq_m) out_log.push_back(out_data);
        @(posedge clk);
        #1;
        if (fl) begin
            cap_q.delete();
            fifo_q.delete();
            infl = 1'b0;
            if (deq_m) dlv++;
        end else begin
            if (deq_m) begin
                void'(cap_q.pop_front());
                dlv++;
            end
            if (infl) cap_q.push_back(infl_val);
            infl = exp_pop;
            if (exp_pop) begin
                infl_val  = fifo_q.pop_front();
                fifo_data = infl_val;
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_reset();
        cap_q.delete();
        infl = 1'b0;
        dlv  = 0;
    endtask

    initial begin
        int base_dlv;
        reset_n    = 1'b0;
        fifo_data  = 16'h0;
        fifo_empty = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        model_reset();
        pop_count  = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_fifo_pop", 32'(fifo_pop), 32'(0));
        check("reset_occupancy", 32'(occupancy), 32'(0));
        check("reset_delivered", 32'(delivered), 32'(0));
        reset_n = 1'b1;

        // Basic stream of 1..4 with the consumer always ready
        push(4, 16'h0001, 1'b0);
        out_ready = 1'b1;
        #2;
        check("first_pop_cycle0", 32'(fifo_pop), 32'(1));
        #(-0);
        @(posedge clk);
        #1;
        infl = 1'b1; infl_val = fifo_q.pop_front(); fifo_data = infl_val;
        fifo_empty = (fifo_q.size() == 0);
        pop_count = 1;
        tick();
        check("valid_cycle2", 32'(out_valid), 32'(1));
        check("data_cycle2", 32'(out_data), 32'(16'h0001));
        run(6);
        check("basic_delivered", 32'(delivered), 32'(4));
        check("basic_count", 32'(out_log.size()), 32'(4));
        for (int i = 0; i < 4; i++) begin
            logic [15:0] v;
            v = out_log[i];
            check("basic_order", 32'(v), 32'(i + 1));
        end

        // Backpressure: 8 entries, consumer stalled for 10 cycles
        out_log.delete();
        pop_count = 0;
        out_ready = 1'b0;
        push(8, 16'h0100, 1'b0);
        run(10);
        check("bp_pops", 32'(pop_count), 32'(2));
        check("bp_occupancy", 32'(occupancy), 32'(2));
        check("bp_data_stable", 32'(out_data), 32'(16'h0100));
        out_ready = 1'b1;
        run(10);
        check("bp_delivered", 32'(delivered), 32'(12));
        for (int i = 0; i < 8; i++) begin
            logic [15:0] v;
            v = out_log[i];
            check("bp_order", 32'(v), 32'(16'h0100 + i));
        end

        // Ready toggling across 20 entries
        base_dlv = int'(dlv);
        push(20, 16'h0200, 1'b0);
        for (int i = 0; i < 50; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        out_ready = 1'b1;
        run(4);
        check("toggle_delivered", 32'(dlv - base_dlv), 32'(20));
        check("toggle_hw_delivered", 32'(delivered), 32'(12 + 20));

        // Flush the cycle after a pop issued with occupancy 2
        base_dlv  = int'(dlv);
        out_ready = 1'b0;
        push(6, 16'h0300, 1'b0);
        run(3);
        check("pre_flush_occ", 32'(occupancy), 32'(2));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        #2;
        check("flush_valid", 32'(out_valid), 32'(0));
        check("flush_occ", 32'(occupancy), 32'(0));
        check("flush_delivered", 32'(delivered), 32'(base_dlv + 1));
        #(-0);
        @(posedge clk);
        #1;
        run(2);

        // Asynchronous reset mid-stream
        out_ready = 1'b1;
        push(10, 16'h0400, 1'b0);
        run(4);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'(0));
        check("arst_pop", 32'(fifo_pop), 32'(0));
        check("arst_delivered", 32'(delivered), 32'(0));
        check("arst_occ", 32'(occupancy), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run(12);

        // Counter wrap for the 4-bit instance
        reset_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        fifo_q.delete();
        push(17, 16'h0500, 1'b0);
        run(22);
        check("wrap_c4", 32'(delivered4), 32'(1));
        check("wrap_c16", 32'(delivered), 32'(17));

        // Randomized traffic with backpressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 1) == 1) push(int'($urandom_range(1, 2)), 16'h0, 1'b1);
            tick();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        run(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
